// File: rtl/ysyx_22041211_csr_trap_seq.sv
// ysyx_22041211_csr_trap_seq
//   Sequencer/arbiter in front of a single-port CSR file. A trap request
//   (ecall or mret) becomes an ordered series of CSR accesses followed by a
//   one-cycle PC redirect. Pipeline CSR instructions share the port and are
//   only serviced in IDLE when no trap is being offered.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   trap_valid/ready             trap handshake; ready only in IDLE
//   trap_is_mret                 0 = ecall/exception, 1 = mret
//   trap_pc, trap_cause          captured on accept
//   csr_req, csr_req_addr/wdata/we  pipeline CSR access
//   csr_gnt                      pipeline access performed this cycle
//   csr_req_rdata                read data back to pipeline (= csr_rdata)
//   csr_addr, csr_wdata, csr_we  to the CSR file
//   csr_rdata                    combinational read data from the CSR file
//   redir_valid, redir_pc        one-cycle PC redirect
module ysyx_22041211_csr_trap_seq #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trap_valid,
    output logic                  trap_ready,
    input  logic                  trap_is_mret,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic [DATA_WIDTH-1:0] trap_cause,
    input  logic                  csr_req,
    input  logic [11:0]           csr_req_addr,
    input  logic [DATA_WIDTH-1:0] csr_req_wdata,
    input  logic                  csr_req_we,
    output logic                  csr_gnt,
    output logic [DATA_WIDTH-1:0] csr_req_rdata,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  csr_we,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  redir_valid,
    output logic [DATA_WIDTH-1:0] redir_pc
);

    typedef enum logic [2:0] {
        IDLE,
        EPC_WR,
        CAUSE_WR,
        VEC_RD,
        MRET_RD
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, cause_q;
    logic                  redir_valid_q, redir_valid_d;
    logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;
    logic                  accept;

    assign accept        = (state_q == IDLE) && trap_valid;
    assign csr_req_rdata = csr_rdata;
    assign redir_valid   = redir_valid_q;
    assign redir_pc      = redir_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            cause_q       <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            // Trap inputs are only sampled on accept; they may change afterwards.
            if (accept) begin
                pc_q    <= trap_pc;
                cause_q <= trap_cause;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        redir_valid_d = 1'b0;       // pulse: cleared unless re-set below
        redir_pc_d    = redir_pc_q;
        trap_ready    = 1'b0;
        csr_gnt       = 1'b0;
        csr_addr      = csr_req_addr;
        csr_wdata     = '0;
        csr_we        = 1'b0;
        case (state_q)
            IDLE: begin
                trap_ready = 1'b1;
                // A trap wins over a same-cycle pipeline request.
                csr_gnt    = csr_req && !trap_valid;
                if (csr_gnt) begin
                    csr_wdata = csr_req_wdata;
                    csr_we    = csr_req_we;
                end
                if (trap_valid)
                    state_d = trap_is_mret ? MRET_RD : EPC_WR;
            end
            EPC_WR: begin
                csr_addr  = MEPC_ADDR;
                csr_wdata = pc_q;
                csr_we    = 1'b1;
                state_d   = CAUSE_WR;
            end
            CAUSE_WR: begin
                csr_addr  = MCAUSE_ADDR;
                csr_wdata = cause_q;
                csr_we    = 1'b1;
                state_d   = VEC_RD;
            end
            VEC_RD: begin
                // Direct mode only: mode bits of mtvec are masked off.
                csr_addr      = MTVEC_ADDR;
                redir_pc_d    = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
                redir_valid_d = 1'b1;
                state_d       = IDLE;
            end
            MRET_RD: begin
                csr_addr      = MEPC_ADDR;
                redir_pc_d    = csr_rdata;
                redir_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22041211_csr_trap_seq.sv
module tb_ysyx_22041211_csr_trap_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0, trap_ready, trap_is_mret = 1'b0;
    logic [31:0] trap_pc = '0, trap_cause = '0;
    logic        csr_req = 1'b0, csr_req_we = 1'b0, csr_gnt;
    logic [11:0] csr_req_addr = '0;
    logic [31:0] csr_req_wdata = '0, csr_req_rdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_we, redir_valid;
    logic [31:0] redir_pc;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_redir[$];

    // CSR file model: combinational read, write on rising edge.
    logic [31:0] csr_mem [0:4095];
    initial for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
    always @(posedge clk) if (!rst && csr_we) csr_mem[csr_addr] <= csr_wdata;
    assign csr_rdata = csr_mem[csr_addr];

    ysyx_22041211_csr_trap_seq dut (
        .clk(clk), .rst(rst),
        .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_is_mret(trap_is_mret),
        .trap_pc(trap_pc), .trap_cause(trap_cause),
        .csr_req(csr_req), .csr_req_addr(csr_req_addr), .csr_req_wdata(csr_req_wdata),
        .csr_req_we(csr_req_we), .csr_gnt(csr_gnt), .csr_req_rdata(csr_req_rdata),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(csr_rdata),
        .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    // Scoreboard: every CSR write and redirect pulse is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (csr_we) begin
                if (exp_wr.size() == 0) chk("unexpected_write", {20'h0, csr_addr}, 32'hFFFF_FFFF);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", {20'h0, csr_addr}, {20'h0, w.addr});
                    chk("wr_data", csr_wdata, w.data);
                end
            end
            if (redir_valid) begin
                if (exp_redir.size() == 0) chk("unexpected_redir", redir_pc, 32'hFFFF_FFFF);
                else chk("redir_pc", redir_pc, exp_redir.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_trap_ready", {31'h0, trap_ready}, 32'd1);
        chk("rst_redir_valid", {31'h0, redir_valid}, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_csr_we", {31'h0, csr_we}, 32'd0);
        step();
        rst = 1'b0;

        // Program mtvec through the pipeline port
        csr_req = 1'b1; csr_req_we = 1'b1; csr_req_addr = 12'h305; csr_req_wdata = 32'h8000_0101;
        push_wr(12'h305, 32'h8000_0101);
        #1 chk("gnt_mtvec_init", {31'h0, csr_gnt}, 32'd1);
        step();
        csr_req = 1'b0; csr_req_we = 1'b0;

        // 1: ecall
        trap_valid = 1'b1; trap_is_mret = 1'b0; trap_pc = 32'h8000_0010; trap_cause = 32'd11;
        push_wr(12'h341, 32'h8000_0010);
        push_wr(12'h342, 32'd11);
        exp_redir.push_back(32'h8000_0100);
        #1 chk("ecall_ready_idle", {31'h0, trap_ready}, 32'd1);
        step();                                            // cycle 1
        trap_valid = 1'b0; trap_pc = 32'hDEAD_0000; trap_cause = 32'd99;
        #1 chk("ecall_ready_c1", {31'h0, trap_ready}, 32'd0);
        step();                                            // cycle 2
        chk("ecall_ready_c2", {31'h0, trap_ready}, 32'd0);
        chk("ecall_mepc", csr_mem[12'h341], 32'h8000_0010);
        step();                                            // cycle 3
        chk("ecall_ready_c3", {31'h0, trap_ready}, 32'd0);
        chk("ecall_redir_c3", {31'h0, redir_valid}, 32'd0);
        chk("ecall_mcause", csr_mem[12'h342], 32'd11);
        step();                                            // cycle 4
        chk("ecall_redir_c4", {31'h0, redir_valid}, 32'd1);
        chk("ecall_ready_c4", {31'h0, trap_ready}, 32'd1);
        step();
        chk("ecall_redir_pulse", {31'h0, redir_valid}, 32'd0);

        // 2: mret with mepc = 0x80000014
        csr_req = 1'b1; csr_req_we = 1'b1; csr_req_addr = 12'h341; csr_req_wdata = 32'h8000_0014;
        push_wr(12'h341, 32'h8000_0014);
        step();
        csr_req = 1'b0; csr_req_we = 1'b0;
        trap_valid = 1'b1; trap_is_mret = 1'b1;
        exp_redir.push_back(32'h8000_0014);
        step();                                            // cycle 1
        trap_valid = 1'b0; trap_is_mret = 1'b0;
        #1 chk("mret_addr_c1", {20'h0, csr_addr}, 32'h341);
        chk("mret_we_c1", {31'h0, csr_we}, 32'd0);
        step();                                            // cycle 2
        chk("mret_redir_c2", {31'h0, redir_valid}, 32'd1);

        // 3: pipeline write then read of mtvec
        csr_req = 1'b1; csr_req_we = 1'b1; csr_req_addr = 12'h305; csr_req_wdata = 32'h8000_0200;
        push_wr(12'h305, 32'h8000_0200);
        #1 chk("pipe_gnt_wr", {31'h0, csr_gnt}, 32'd1);
        step();
        csr_req_we = 1'b0;
        #1 chk("pipe_gnt_rd", {31'h0, csr_gnt}, 32'd1);
        chk("pipe_rdata", csr_req_rdata, 32'h8000_0200);
        step();
        csr_req = 1'b0;

        // 4: trap and pipeline request in the same cycle
        csr_req = 1'b1; csr_req_we = 1'b1; csr_req_addr = 12'h340; csr_req_wdata = 32'hDEAD_BEEF;
        trap_valid = 1'b1; trap_pc = 32'h8000_0040; trap_cause = 32'd11;
        push_wr(12'h341, 32'h8000_0040);
        push_wr(12'h342, 32'd11);
        exp_redir.push_back(32'h8000_0200);
        #1 chk("arb_gnt_idle", {31'h0, csr_gnt}, 32'd0);
        chk("arb_we_idle", {31'h0, csr_we}, 32'd0);
        step();
        trap_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1 chk("arb_gnt_busy", {31'h0, csr_gnt}, 32'd0);
            step();
        end
        push_wr(12'h340, 32'hDEAD_BEEF);
        chk("arb_gnt_after", {31'h0, csr_gnt}, 32'd1);
        step();
        csr_req = 1'b0; csr_req_we = 1'b0;
        chk("arb_mscratch", csr_mem[12'h340], 32'hDEAD_BEEF);

        // 5: reset during CAUSE_WR
        trap_valid = 1'b1; trap_pc = 32'h8000_0080; trap_cause = 32'd7;
        push_wr(12'h341, 32'h8000_0080);
        step();                                            // EPC_WR
        trap_valid = 1'b0;
        step();                                            // CAUSE_WR
        rst = 1'b1;
        #1 chk("rst_mid_ready", {31'h0, trap_ready}, 32'd1);
        chk("rst_mid_we", {31'h0, csr_we}, 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rst_mid_redir", {31'h0, redir_valid}, 32'd0);
            step();
        end
        chk("rst_mid_mcause", csr_mem[12'h342], 32'd11);

        // 6: ecall accepted in the mret redirect cycle
        trap_valid = 1'b1; trap_is_mret = 1'b1;
        exp_redir.push_back(32'h8000_0080);
        step();
        trap_valid = 1'b0; trap_is_mret = 1'b0;
        step();                                            // mret redirect cycle
        chk("b2b_redir_mret", {31'h0, redir_valid}, 32'd1);
        chk("b2b_ready", {31'h0, trap_ready}, 32'd1);
        trap_valid = 1'b1; trap_pc = 32'h8000_00A0; trap_cause = 32'd2;
        push_wr(12'h341, 32'h8000_00A0);
        push_wr(12'h342, 32'd2);
        exp_redir.push_back(32'h8000_0200);
        step();
        trap_valid = 1'b0;
        chk("b2b_redir_c1", {31'h0, redir_valid}, 32'd0);
        step();
        step();
        step();
        chk("b2b_redir_c4", {31'h0, redir_valid}, 32'd1);
        step();
        step();
        chk("sb_wr_empty", exp_wr.size(), 32'd0);
        chk("sb_redir_empty", exp_redir.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
